// File: rtl/mult_share_arbiter.sv
// Shares one signed 8x8 array multiplier among four requesters.
// A round-robin arbiter feeds a two-stage pipeline (operand register S1 and
// result register S2). The pipeline sustains one product per cycle and
// honours backpressure from the response consumer.

module mult_share_arbiter #(
  parameter int unsigned NREQ = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  req_valid,
  input  logic [31:0] req_x,
  input  logic [31:0] req_y,
  output logic [3:0]  req_ready,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [1:0]  rsp_id,
  output logic [15:0] rsp_p,
  output logic [15:0] ops_done
);

  // Stage S1: operands waiting for the multiplier
  logic        v1_q, v1_d;
  logic [1:0]  id1_q, id1_d;
  logic [7:0]  x1_q, x1_d;
  logic [7:0]  y1_q, y1_d;

  // Stage S2: finished product waiting for the consumer
  logic        v2_q, v2_d;
  logic [1:0]  id2_q, id2_d;
  logic [15:0] p2_q, p2_d;

  logic [1:0]  ptr_q, ptr_d;
  logic [15:0] ops_q, ops_d;

  logic        adv1, adv2;
  logic        grant_found;
  logic [1:0]  grant_idx;
  logic        accept;
  logic [15:0] mult_p;

  // Pipeline advance conditions; S1 may move whenever S2 frees up this cycle
  always_comb begin
    adv2 = !v2_q || rsp_ready;
    adv1 = !v1_q || adv2;
  end

  // Round-robin search starting at the pointer, wrapping modulo 4
  always_comb begin
    logic [1:0] idx;
    grant_found = 1'b0;
    grant_idx   = ptr_q;
    idx         = ptr_q;
    for (int unsigned k = 0; k < NREQ; k++) begin
      idx = ptr_q + 2'(k);
      if (!grant_found && req_valid[idx]) begin
        grant_found = 1'b1;
        grant_idx   = idx;
      end
    end
  end

  // Reset takes priority over a coincident request, so gate the accept with it
  always_comb begin
    accept    = grant_found && adv1 && !rst;
    req_ready = accept ? (4'b0001 << grant_idx) : 4'b0000;
  end

  main u_main (
    .x (x1_q),
    .y (y1_q),
    .p (mult_p)
  );

  // Next-state for both pipeline stages, the pointer and the handshake counter
  always_comb begin
    v1_d  = v1_q;
    id1_d = id1_q;
    x1_d  = x1_q;
    y1_d  = y1_q;
    v2_d  = v2_q;
    id2_d = id2_q;
    p2_d  = p2_q;
    ptr_d = ptr_q;
    ops_d = ops_q;

    if (adv1) begin
      v1_d = accept;
      if (accept) begin
        id1_d = grant_idx;
        x1_d  = req_x[{grant_idx, 3'b000} +: 8];
        y1_d  = req_y[{grant_idx, 3'b000} +: 8];
      end
    end

    if (adv2) begin
      v2_d  = v1_q;
      id2_d = id1_q;
      p2_d  = mult_p;
    end

    if (accept) begin
      ptr_d = grant_idx + 2'd1;
    end

    if (v2_q && rsp_ready) begin
      ops_d = ops_q + 16'd1;
    end
  end

  // State registers with synchronous reset; in-flight work is dropped
  always_ff @(posedge clk) begin
    if (rst) begin
      v1_q  <= 1'b0;
      id1_q <= 2'd0;
      x1_q  <= 8'd0;
      y1_q  <= 8'd0;
      v2_q  <= 1'b0;
      id2_q <= 2'd0;
      p2_q  <= 16'd0;
      ptr_q <= 2'd0;
      ops_q <= 16'd0;
    end else begin
      v1_q  <= v1_d;
      id1_q <= id1_d;
      x1_q  <= x1_d;
      y1_q  <= y1_d;
      v2_q  <= v2_d;
      id2_q <= id2_d;
      p2_q  <= p2_d;
      ptr_q <= ptr_d;
      ops_q <= ops_d;
    end
  end

  // Response outputs come straight from S2
  always_comb begin
    rsp_valid = v2_q;
    rsp_id    = id2_q;
    rsp_p     = p2_q;
    ops_done  = ops_q;
  end

endmodule

// Signed 8x8 array multiplier built from eight rows of ripple-carry adders.
// Rows 0..6 add sign-extended x shifted by the row index when y[r] is set;
// row 7 carries negative weight, so it adds the two's complement instead.
module main (
  input  logic [7:0]  x,
  input  logic [7:0]  y,
  output logic [15:0] p
);

  function automatic logic [15:0] rca16(input logic [15:0] a, input logic [15:0] b,
                                        input logic cin);
    logic [15:0] s;
    logic        c;
    s = '0;
    c = cin;
    for (int i = 0; i < 16; i++) begin
      s[i] = a[i] ^ b[i] ^ c;
      c    = (a[i] & b[i]) | (a[i] & c) | (b[i] & c);
    end
    return s;
  endfunction

  logic [15:0] xe;
  logic [15:0] pp   [8];
  logic [15:0] rows [9];

  // Partial products, one per multiplier bit
  always_comb begin
    xe = {{8{x[7]}}, x};
    for (int r = 0; r < 8; r++) begin
      pp[r] = y[r] ? (xe << r) : 16'd0;
    end
  end

  // Accumulate the rows; ~pp + 1 subtracts the sign-bit row
  always_comb begin
    rows[0] = 16'd0;
    for (int r = 0; r < 7; r++) begin
      rows[r + 1] = rca16(rows[r], pp[r], 1'b0);
    end
    rows[8] = rca16(rows[7], ~pp[7], 1'b1);
    p       = rows[8];
  end

endmodule

// File: tb/tb_mult_share_arbiter.sv
// Randomised and directed bench for mult_share_arbiter. A reference model
// tracks in-flight operations as a queue of expected responses; a monitor
// on the falling edge compares the DUT outputs against it.

module tb_mult_share_arbiter;

  logic        clk;
  logic        rst;
  logic [3:0]  vld;
  logic [7:0]  xs [4];
  logic [7:0]  ys [4];
  logic [31:0] req_x, req_y;
  logic [3:0]  req_ready;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [1:0]  rsp_id;
  logic [15:0] rsp_p;
  logic [15:0] ops_done;

  assign req_x = {xs[3], xs[2], xs[1], xs[0]};
  assign req_y = {ys[3], ys[2], ys[1], ys[0]};

  mult_share_arbiter dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (vld),
    .req_x     (req_x),
    .req_y     (req_y),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_p     (rsp_p),
    .ops_done  (ops_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  id;
    logic [15:0] p;
    int          e;
  } ent_t;

  ent_t        q[$];
  int          edge_n = 0;
  int          m_ptr = 0;
  int          m_ops = 0;
  logic [3:0]  acc_evt = '0;
  int          n_checks = 0;
  int          n_fail = 0;

  task automatic chk(input string nm, input int unsigned act, input int unsigned exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int pick(input logic [3:0] v, input int ptr);
    for (int k = 0; k < 4; k++) begin
      if (v[(ptr + k) % 4]) return (ptr + k) % 4;
    end
    return -1;
  endfunction

  function automatic logic [15:0] prod(input logic [7:0] a, input logic [7:0] b);
    logic signed [15:0] r;
    r = $signed({{8{a[7]}}, a}) * $signed({{8{b[7]}}, b});
    return r;
  endfunction

  // Reference model: updates at each rising edge from the driven inputs only
  initial begin
    int   cur;
    int   g;
    bit   vis;
    bit   adv;
    ent_t e;
    forever begin
      @(posedge clk);
      cur = edge_n;
      edge_n++;
      acc_evt = '0;
      if (rst) begin
        q.delete();
        m_ptr = 0;
        m_ops = 0;
      end else begin
        vis = (q.size() > 0) && (cur >= q[0].e + 1);
        adv = (q.size() < 2) || rsp_ready;
        g   = pick(vld, m_ptr);
        if (vis && rsp_ready) begin
          void'(q.pop_front());
          m_ops = (m_ops + 1) & 32'hFFFF;
        end
        if (g >= 0 && adv) begin
          e.id = 2'(g);
          e.p  = prod(xs[g], ys[g]);
          e.e  = edge_n;
          q.push_back(e);
          m_ptr = (g + 1) % 4;
          acc_evt[g] = 1'b1;
        end
      end
    end
  end

  // Monitor: compare DUT outputs with the model mid-cycle
  initial begin
    logic [3:0] exp_rdy;
    int         g;
    bit         exp_v;
    forever begin
      @(negedge clk);
      exp_rdy = '0;
      if (!rst) begin
        g = pick(vld, m_ptr);
        if (g >= 0 && (q.size() < 2 || rsp_ready)) exp_rdy[g] = 1'b1;
      end
      chk("req_ready", 32'(req_ready), 32'(exp_rdy));
      exp_v = (q.size() > 0) && (edge_n >= q[0].e + 1);
      chk("rsp_valid", 32'(rsp_valid), 32'(exp_v));
      if (exp_v && rsp_valid) begin
        chk("rsp_id", 32'(rsp_id), 32'(q[0].id));
        chk("rsp_p", 32'(rsp_p), 32'(q[0].p));
      end
      chk("ops_done", 32'(ops_done), 32'(m_ops));
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic send(input int i, input logic [7:0] x, input logic [7:0] y);
    bit ok;
    ok    = 1'b0;
    xs[i] = x;
    ys[i] = y;
    vld[i] = 1'b1;
    for (int n = 0; n < 40; n++) begin
      tick();
      if (acc_evt[i]) begin
        ok = 1'b1;
        break;
      end
    end
    vld[i] = 1'b0;
    chk("accept_timeout", 32'(ok), 32'd1);
  endtask

  logic [7:0]  cx [4];
  logic [7:0]  cy [4];
  logic [15:0] cp [4];
  int          ord [8];
  int          cnt;
  logic [15:0] p_hold;

  initial begin
    rst = 1'b1;
    vld = '0;
    rsp_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      xs[i] = '0;
      ys[i] = '0;
    end
    tick();
    tick();
    rst = 1'b0;
    #1;
    chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("reset_ops_done", 32'(ops_done), 32'd0);
    #1;

    // Single op: 5 * -3
    rsp_ready = 1'b1;
    send(2, 8'h05, 8'hFD);
    tick();
    chk("single_valid", 32'(rsp_valid), 32'd1);
    chk("single_id", 32'(rsp_id), 32'd2);
    chk("single_p", 32'(rsp_p), 32'hFFF1);
    tick();
    chk("single_ops", 32'(ops_done), 32'd1);

    // Corner products
    cx[0] = 8'h80; cy[0] = 8'h80; cp[0] = 16'h4000;
    cx[1] = 8'h80; cy[1] = 8'h7F; cp[1] = 16'hC080;
    cx[2] = 8'h7F; cy[2] = 8'h7F; cp[2] = 16'h3F01;
    cx[3] = 8'h00; cy[3] = 8'hFF; cp[3] = 16'h0000;
    for (int c = 0; c < 4; c++) begin
      send(0, cx[c], cy[c]);
      tick();
      chk("corner_p", 32'(rsp_p), 32'(cp[c]));
    end
    tick();

    // Round robin with everybody valid
    do_reset();
    rsp_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      xs[i] = 8'($urandom);
      ys[i] = 8'($urandom);
    end
    vld = 4'b1111;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      ord[c] = -1;
      for (int i = 0; i < 4; i++) if (req_ready[i]) ord[c] = i;
      tick();
      for (int i = 0; i < 4; i++) begin
        if (acc_evt[i]) begin
          xs[i] = 8'($urandom);
          ys[i] = 8'($urandom);
        end
      end
    end
    vld = '0;
    for (int c = 0; c < 8; c++) chk("rr_order", 32'(ord[c]), 32'(c % 4));
    repeat (4) tick();

    // Backpressure: stream from requester 1 while the consumer stalls
    rsp_ready = 1'b0;
    xs[1] = 8'($urandom);
    ys[1] = 8'($urandom);
    vld[1] = 1'b1;
    cnt = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (req_ready[1]) cnt++;
      if (c == 3) p_hold = rsp_p;
      tick();
      if (acc_evt[1]) begin
        xs[1] = 8'($urandom);
        ys[1] = 8'($urandom);
      end
    end
    chk("bp_accepts", 32'(cnt), 32'd2);
    chk("bp_hold_p", 32'(rsp_p), 32'(p_hold));
    rsp_ready = 1'b1;
    #1;
    chk("bp_resume", 32'(req_ready), 32'b0010);
    for (int c = 0; c < 4; c++) begin
      tick();
      if (acc_evt[1]) begin
        xs[1] = 8'($urandom);
        ys[1] = 8'($urandom);
      end
    end
    vld[1] = 1'b0;
    repeat (4) tick();

    // Pointer skip
    do_reset();
    rsp_ready = 1'b1;
    send(3, 8'h11, 8'h22);
    send(0, 8'hF0, 8'h03);
    xs[0] = 8'h01; ys[0] = 8'h02;
    xs[1] = 8'h03; ys[1] = 8'h04;
    vld[0] = 1'b1;
    vld[1] = 1'b1;
    #1;
    chk("skip_grant", 32'(req_ready), 32'b0010);
    for (int n = 0; n < 10 && vld != 4'b0000; n++) begin
      tick();
      for (int i = 0; i < 2; i++) if (acc_evt[i]) vld[i] = 1'b0;
    end
    vld = '0;
    repeat (4) tick();

    // Reset with two ops in flight and a request held across it
    rsp_ready = 1'b0;
    send(2, 8'h09, 8'h07);
    send(2, 8'hC3, 8'h5A);
    xs[3] = 8'h33;
    ys[3] = 8'hEE;
    vld[3] = 1'b1;
    rst = 1'b1;
    #1;
    chk("rst_ready", 32'(req_ready), 32'd0);
    tick();
    rst = 1'b0;
    #1;
    chk("post_rst_valid", 32'(rsp_valid), 32'd0);
    chk("post_rst_ops", 32'(ops_done), 32'd0);
    chk("post_rst_ready", 32'(req_ready), 32'b1000);
    tick();
    vld[3] = 1'b0;
    rsp_ready = 1'b1;
    repeat (4) tick();

    // Random traffic with random stalls and occasional reset
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < 4; i++) begin
        if (acc_evt[i]) vld[i] = 1'b0;
        if (!vld[i] && ($urandom_range(99) < 40)) begin
          xs[i] = 8'($urandom);
          ys[i] = 8'($urandom);
          vld[i] = 1'b1;
        end
      end
      rsp_ready = ($urandom_range(99) < 70);
      rst = ($urandom_range(999) < 5);
      tick();
    end
    rst = 1'b0;
    vld = '0;
    rsp_ready = 1'b1;
    repeat (6) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
